// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port,
// with at most one transaction outstanding and a starvation bound for fetch.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [3:0]      ls_be_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            owner_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       sel;
    logic       issue;
    logic       rsp;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        sel     = owner_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i || ls_req_i) begin
                    issue   = 1'b1;
                    sel     = ls_req_i && !(if_req_i && (starve_q == STARVE_LIM));
                    owner_d = sel;
                    state_d = mem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                issue = 1'b1;
                if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates every handshake output so they drop without waiting for a clock edge
    always_comb begin
        rsp         = (state_q == WAIT) && mem_rvalid_i && !rst_i;
        mem_req_o   = issue && !rst_i;
        if_gnt_o    = mem_req_o && mem_gnt_i && !sel;
        ls_gnt_o    = mem_req_o && mem_gnt_i && sel;
        mem_we_o    = mem_req_o && sel && ls_we_i;
        mem_be_o    = mem_req_o ? (sel ? ls_be_i : 4'hF) : 4'h0;
        mem_addr_o  = mem_req_o ? (sel ? ls_addr_i : if_addr_i) : '0;
        mem_wdata_o = (mem_req_o && sel) ? ls_wdata_i : '0;
        if_rvalid_o = rsp && !owner_q;
        ls_rvalid_o = rsp && owner_q;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
        owner_o     = rst_i ? 1'b0 : sel;
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_o || !if_req_i) begin
            starve_d = 4'd0;
        end else if (ls_gnt_o && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vectors for the basic and corner sequences,
// then a held-request streaming phase checked through a response scoreboard.
module tb_mem_port_arbiter;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [3:0]  F  = 4'hF;
    localparam logic [3:0]  B0 = 4'h0;
    localparam logic [31:0] IFA = 32'h0000_0700;
    localparam logic [31:0] LSA = 32'h0000_0800;

    typedef struct {
        logic ifr; logic [31:0] ifa; logic lsr; logic lswe; logic [3:0] lsbe;
        logic [31:0] lsa; logic [31:0] lsd; logic mg; logic mrv; logic [31:0] mrd;
        logic emreq; logic emwe; logic [3:0] embe; logic [31:0] emaddr; logic [31:0] emwd;
        logic eifg; logic elsg; logic eifrv; logic elsrv; logic [31:0] erd; logic eown;
    } vec_t;

    typedef struct {
        logic        own;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, owner;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[17];
    rsp_t sb_q[$];

    mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata),
        .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .owner_o(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic drive(input vec_t v);
        if_req = v.ifr;  if_addr = v.ifa;
        ls_req = v.lsr;  ls_we = v.lswe; ls_be = v.lsbe; ls_addr = v.lsa; ls_wdata = v.lsd;
        mem_gnt = v.mg;  mem_rvalid = v.mrv; mem_rdata = v.mrd;
    endtask

    task automatic check_row(input vec_t v, input string nm, input int idx);
        logic [138:0] act, exp;
        act = {mem_req, mem_we, mem_be, (v.emreq ? mem_addr : Z), (v.emwe ? mem_wdata : Z),
               if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, ls_rdata, owner};
        exp = {v.emreq, v.emwe, v.embe, (v.emreq ? v.emaddr : Z), (v.emwe ? v.emwd : Z),
               v.eifg, v.elsg, v.eifrv, v.elsrv, (v.eifrv ? v.erd : Z), (v.elsrv ? v.erd : Z),
               v.eown};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm, input int idx);
        @(negedge clk);
        drive(v);
        #1 check_row(v, nm, idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rsp_t e;
        logic        rsp_pend, if_hold;
        logic [31:0] rsp_data, act_d;
        int          seen;

        // ifr ifa lsr we be lsa lsd mg mrv mrd | mreq we be addr wd ifg lsg ifrv lsrv rd own
        vecs[0]  = '{H,32'h100,L,L,B0,Z,Z,H,L,Z, H,L,F,32'h100,Z,H,L,L,L,Z,L};
        vecs[1]  = '{L,Z,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,L};
        vecs[2]  = '{L,Z,L,L,B0,Z,Z,L,H,32'hDEADBEEF, L,L,B0,Z,Z,L,L,H,L,32'hDEADBEEF,L};
        vecs[3]  = '{L,Z,L,L,B0,Z,Z,L,H,32'h12345678, L,L,B0,Z,Z,L,L,L,L,Z,L};
        vecs[4]  = '{L,Z,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,L};
        vecs[5]  = '{H,32'h200,H,H,4'h3,32'h300,32'h1234,H,L,Z, H,H,4'h3,32'h300,32'h1234,L,H,L,L,Z,H};
        vecs[6]  = '{H,32'h200,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,H};
        vecs[7]  = '{H,32'h200,L,L,B0,Z,Z,L,H,32'hA5A5, L,L,B0,Z,Z,L,L,L,H,32'hA5A5,H};
        vecs[8]  = '{H,32'h200,L,L,B0,Z,Z,L,L,Z, H,L,F,32'h200,Z,L,L,L,L,Z,L};
        vecs[9]  = '{H,32'h200,H,L,F,32'h400,Z,L,H,32'h11111111, H,L,F,32'h200,Z,L,L,L,L,Z,L};
        vecs[10] = '{H,32'h200,H,L,F,32'h400,Z,L,L,Z, H,L,F,32'h200,Z,L,L,L,L,Z,L};
        vecs[11] = '{H,32'h200,H,L,F,32'h400,Z,H,L,Z, H,L,F,32'h200,Z,H,L,L,L,Z,L};
        vecs[12] = '{L,Z,H,L,F,32'h400,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,L};
        vecs[13] = '{L,Z,H,L,F,32'h400,Z,L,H,32'hCAFEF00D, L,L,B0,Z,Z,L,L,H,L,32'hCAFEF00D,L};
        vecs[14] = '{L,Z,H,L,F,32'h400,Z,H,L,Z, H,L,F,32'h400,Z,L,H,L,L,Z,H};
        vecs[15] = '{L,Z,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,H};
        vecs[16] = '{L,Z,L,L,B0,Z,Z,L,H,32'h0BADF00D, L,L,B0,Z,Z,L,L,L,H,32'h0BADF00D,H};

        // Requests and responses present while reset is held must not leak out
        v = '{H,32'h100,H,H,F,32'h300,Z,H,H,32'hFFFF, L,L,B0,Z,Z,L,L,L,L,Z,L};
        drive(v);
        #3 check_row(v, "reset_state", 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[0]);
        #1 check_row(vecs[0], "vec", 0);
        for (int i = 1; i < 17; i++) step(vecs[i], "vec", i);

        // Asynchronous reset pulse between clock edges while a load is outstanding
        step('{L,Z,H,L,F,32'h500,Z,H,L,Z, H,L,F,32'h500,Z,L,H,L,L,Z,H}, "rst_seq", 0);
        v = '{L,Z,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,H};
        step(v, "rst_seq", 1);
        #1 rst = 1'b1;
        v.eown = L;
        #1 check_row(v, "rst_seq", 2);
        #1 rst = 1'b0;
        step('{L,Z,L,L,B0,Z,Z,L,H,32'h77, L,L,B0,Z,Z,L,L,L,L,Z,L}, "rst_seq", 3);
        step('{H,32'h600,L,L,B0,Z,Z,H,L,Z, H,L,F,32'h600,Z,H,L,L,L,Z,L}, "rst_seq", 4);
        step('{L,Z,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,L}, "rst_seq", 5);
        step('{L,Z,L,L,B0,Z,Z,L,H,32'h600D, L,L,B0,Z,Z,L,L,H,L,32'h600D,L}, "rst_seq", 6);

        // Both requesters held: four load/store grants, then fetch, twice over
        for (int k = 0; k < 10; k++) begin
            e.own  = (k == 4 || k == 9) ? 1'b0 : 1'b1;
            e.data = mem_val(e.own ? LSA : IFA);
            sb_q.push_back(e);
        end
        rsp_pend = 1'b0;
        rsp_data = Z;
        if_hold  = 1'b1;
        seen     = 0;
        for (int cyc = 0; cyc < 200 && seen < 10; cyc++) begin
            @(negedge clk);
            if_req = if_hold; if_addr = IFA;
            ls_req = 1'b1; ls_we = 1'b0; ls_be = F; ls_addr = LSA; ls_wdata = Z;
            mem_gnt = 1'b1; mem_rvalid = rsp_pend; mem_rdata = rsp_pend ? rsp_data : Z;
            #1;
            rsp_pend = 1'b0;
            if_hold  = 1'b1;
            if (mem_req && mem_gnt) begin
                rsp_pend = 1'b1;
                rsp_data = mem_val(mem_addr);
            end
            if (if_gnt) if_hold = 1'b0;
            if (if_rvalid || ls_rvalid) begin
                checks++;
                seen++;
                act_d = if_rvalid ? if_rdata : ls_rdata;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_rsp extra response actual=%h required=none", act_d);
                end else begin
                    e = sb_q.pop_front();
                    if ({ls_rvalid, if_rvalid, act_d} !== {e.own, !e.own, e.data}) begin
                        failures++;
                        $display("FAIL stream_rsp[%0d] actual=ls%0b/if%0b %h required=ls%0b/if%0b %h",
                                 seen, ls_rvalid, if_rvalid, act_d, e.own, !e.own, e.data);
                    end
                end
            end
        end
        checks++;
        if (seen != 10) begin
            failures++;
            $display("FAIL stream_count actual=%0d required=10", seen);
        end
        @(negedge clk);
        drive('{L,Z,L,L,B0,Z,Z,L,L,Z, L,L,B0,Z,Z,L,L,L,L,Z,L});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
